// File: rtl/uart_pkg.sv
// Shared types and defaults for the parametrised UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int unsigned DEF_BAUD_DIV = 2604;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO queueing transmit payloads; rdata is valid whenever !empty.
module uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr_en, rd_en;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;
  assign rdata = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter: configurable width, parity and stop bits, fed by a small FIFO.
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned BAUD_DIV   = DEF_BAUD_DIV,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trmt,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 TX,
  output logic                 tx_done,
  output logic                 busy,
  output logic                 fifo_full,
  output logic                 overflow
);

  localparam int unsigned BaudW = $clog2(BAUD_DIV);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  tx_state_t            state_q;
  logic [BaudW-1:0]     baud_q;
  logic [BitW-1:0]      bit_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_empty, pop;
  logic                 par_q, tx_q, frame_end_q, done_q, line_active_q, overflow_q;
  logic                 bit_end, last_data, last_stop;

  uart_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (trmt),
    .pop  (pop),
    .wdata(tx_data),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign bit_end   = (baud_q == BaudW'(BAUD_DIV - 1));
  assign last_data = (bit_q == BitW'(DATA_BITS - 1));
  assign last_stop = (bit_q == BitW'(STOP_BITS - 1));
  assign pop       = !fifo_empty &&
                     ((state_q == IDLE) || ((state_q == STOP) && bit_end && last_stop));

  // The line register follows the FSM by one clock; tx_done is delayed to match it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      shreg_q       <= '0;
      par_q         <= 1'b0;
      tx_q          <= 1'b1;
      frame_end_q   <= 1'b0;
      done_q        <= 1'b0;
      line_active_q <= 1'b0;
    end else begin
      frame_end_q   <= 1'b0;
      done_q        <= frame_end_q;
      line_active_q <= (state_q != IDLE);
      baud_q        <= bit_end ? '0 : baud_q + 1'b1;
      case (state_q)
        START:   tx_q <= 1'b0;
        DATA:    tx_q <= shreg_q[0];
        PARITY:  tx_q <= par_q;
        default: tx_q <= 1'b1;
      endcase
      case (state_q)
        IDLE: baud_q <= '0;
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            bit_q   <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg_q <= shreg_q >> 1;
            if (last_data) begin
              bit_q   <= '0;
              state_q <= (PARITY_EN != 0) ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            bit_q   <= '0;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (last_stop) begin
              frame_end_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
      if (pop) begin
        shreg_q <= fifo_rdata;
        par_q   <= (^fifo_rdata) ^ (PARITY_ODD != 0);
        state_q <= START;
        baud_q  <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overflow_q <= 1'b0;
    else        overflow_q <= trmt && fifo_full;
  end

  assign TX       = tx_q;
  assign tx_done  = done_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE) || line_active_q || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Directed bench: 8N1, 8E2, 8O1 and 5N1 transmitters sharing one clock and reset.
module tb_uart_tx_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] trmt_v;
  logic [7:0] tdata;
  logic [3:0] tx_v, done_v, busy_v, full_v, ovf_v;
  int         tests, fails;

  always #10 clk = ~clk;

  uart_tx_fifo_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY_EN(0), .PARITY_ODD(0),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_v[0]), .tx_data(tdata), .TX(tx_v[0]),
    .tx_done(done_v[0]), .busy(busy_v[0]), .fifo_full(full_v[0]), .overflow(ovf_v[0]));
  uart_tx_fifo_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY_EN(1), .PARITY_ODD(0),
                       .STOP_BITS(2), .FIFO_DEPTH(4)) u_8e2 (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_v[1]), .tx_data(tdata), .TX(tx_v[1]),
    .tx_done(done_v[1]), .busy(busy_v[1]), .fifo_full(full_v[1]), .overflow(ovf_v[1]));
  uart_tx_fifo_param #(.DATA_BITS(8), .BAUD_DIV(16), .PARITY_EN(1), .PARITY_ODD(1),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_v[2]), .tx_data(tdata), .TX(tx_v[2]),
    .tx_done(done_v[2]), .busy(busy_v[2]), .fifo_full(full_v[2]), .overflow(ovf_v[2]));
  uart_tx_fifo_param #(.DATA_BITS(5), .BAUD_DIV(16), .PARITY_EN(0), .PARITY_ODD(0),
                       .STOP_BITS(1), .FIFO_DEPTH(4)) u_5n1 (
    .clk(clk), .rst_n(rst_n), .trmt(trmt_v[3]), .tx_data(tdata[4:0]), .TX(tx_v[3]),
    .tx_done(done_v[3]), .busy(busy_v[3]), .fifo_full(full_v[3]), .overflow(ovf_v[3]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [7:0] data);
    trmt_v[d] = 1'b1;
    tdata     = data;
    @(negedge clk);
    trmt_v[d] = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then samples every clock of the frame plus one.
  task automatic capture(input int d, input int nbits, output logic [15:0] bits,
                         output int waited, output int done_at, output int done_cnt,
                         output bit stable, output bit busy_ok);
    bits = '0; waited = 0; done_at = -1; done_cnt = 0; stable = 1'b1; busy_ok = 1'b1;
    while (tx_v[d] !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    for (int c = 0; c <= nbits * 16; c++) begin
      if (c > 0) @(negedge clk);
      if (c < nbits * 16) begin
        if (c % 16 == 0) bits[c/16] = tx_v[d];
        else if (tx_v[d] !== bits[c/16]) stable = 1'b0;
        if (busy_v[d] !== 1'b1) busy_ok = 1'b0;
      end
      if (c > 0 && done_v[d] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
    end
  endtask

  task automatic run_frame(input string tag, input int d, input logic [7:0] data,
                           input int nbits, input logic [15:0] exp_bits);
    logic [15:0] b;
    int          w, da, dc;
    bit          st, bz;
    fork
      push(d, data);
      capture(d, nbits, b, w, da, dc, st, bz);
    join
    check({tag, "_started"}, 32'(w < 400), 32'd1);
    check({tag, "_bits"}, 32'(b), 32'(exp_bits));
    check({tag, "_done_at"}, 32'(da), 32'(nbits * 16));
    check({tag, "_done_cnt"}, 32'(dc), 32'd1);
    check({tag, "_stable"}, 32'(st), 32'd1);
    check({tag, "_busy"}, 32'(bz), 32'd1);
  endtask

  initial begin
    logic [15:0] b;
    int          w, da, dc, lows;
    bit          st, bz;
    logic [15:0] fb [5];
    int          fw [5], fd [5], fc [5];
    bit          fs [5], fbz [5];
    logic [15:0] exp3 [5];

    tests = 0; fails = 0;
    rst_n = 1'b0; trmt_v = '0; tdata = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx_v), 32'hF);
    check("rst_done", 32'(done_v), 32'h0);
    check("rst_busy", 32'(busy_v), 32'h0);
    check("rst_full", 32'(full_v), 32'h0);
    check("rst_ovf", 32'(ovf_v), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 0xAA with start latency of two edges.
    push(0, 8'hAA);
    check("lat_tx_k0", 32'(tx_v[0]), 32'd1);
    check("lat_busy", 32'(busy_v[0]), 32'd1);
    @(negedge clk);
    check("lat_tx_k1", 32'(tx_v[0]), 32'd1);
    @(negedge clk);
    check("lat_tx_k2", 32'(tx_v[0]), 32'd0);
    capture(0, 10, b, w, da, dc, st, bz);
    check("8n1_wait", 32'(w), 32'd0);
    check("8n1_bits", 32'(b), 32'h354);
    check("8n1_done_at", 32'(da), 32'd160);
    check("8n1_done_cnt", 32'(dc), 32'd1);
    check("8n1_stable", 32'(st), 32'd1);
    check("8n1_busy", 32'(bz), 32'd1);
    check("8n1_busy_end", 32'(busy_v[0]), 32'd0);

    // Parity variants.
    run_frame("8e2", 1, 8'hEB, 12, 16'hDD6);
    run_frame("8o1", 2, 8'hEB, 11, 16'h7D6);

    // The first push is popped at once, so the fifth push is the one that fills the FIFO.
    exp3[0] = 16'h222; exp3[1] = 16'h244; exp3[2] = 16'h266;
    exp3[3] = 16'h288; exp3[4] = 16'h2AA;
    fork
      begin
        for (int f = 0; f < 5; f++) capture(0, 10, fb[f], fw[f], fd[f], fc[f], fs[f], fbz[f]);
      end
      begin
        trmt_v[0] = 1'b1;
        tdata = 8'h11; @(negedge clk);
        tdata = 8'h22; @(negedge clk);
        tdata = 8'h33; @(negedge clk);
        tdata = 8'h44; @(negedge clk);
        check("q_not_full", 32'(full_v[0]), 32'd0);
        tdata = 8'h55; @(negedge clk);
        check("q_full", 32'(full_v[0]), 32'd1);
        check("q_no_ovf", 32'(ovf_v[0]), 32'd0);
        tdata = 8'h66; @(negedge clk);
        trmt_v[0] = 1'b0;
        check("ovf_pulse", 32'(ovf_v[0]), 32'd1);
        check("ovf_full", 32'(full_v[0]), 32'd1);
        @(negedge clk);
        check("ovf_clear", 32'(ovf_v[0]), 32'd0);
      end
    join
    for (int f = 0; f < 5; f++) begin
      check($sformatf("q%0d_bits", f), 32'(fb[f]), 32'(exp3[f]));
      if (f > 0) check($sformatf("q%0d_gap", f), 32'(fw[f]), 32'd0);
      check($sformatf("q%0d_done_at", f), 32'(fd[f]), 32'd160);
      check($sformatf("q%0d_done_cnt", f), 32'(fc[f]), 32'd1);
      check($sformatf("q%0d_stable", f), 32'(fs[f]), 32'd1);
      check($sformatf("q%0d_busy", f), 32'(fbz[f]), 32'd1);
    end
    check("q_busy_end", 32'(busy_v[0]), 32'd0);
    lows = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1) lows++;
    end
    check("q_no_extra_frame", 32'(lows), 32'd0);
    check("q_full_end", 32'(full_v[0]), 32'd0);

    // Asynchronous reset in the middle of the data bits of a 0x00 frame.
    push(0, 8'h00);
    repeat (54) @(negedge clk);
    check("mid_tx_low", 32'(tx_v[0]), 32'd0);
    check("mid_busy", 32'(busy_v[0]), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(tx_v[0]), 32'd1);
    check("arst_busy", 32'(busy_v[0]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_tx", 32'(tx_v[0]), 32'd1);
    run_frame("post_rst", 0, 8'h5A, 10, 16'h2B4);

    // Five data bits.
    run_frame("5n1", 3, 8'h13, 7, 16'h066);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
